// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC and assembles 32-bit little-endian words
// from a byte-serial memory port. Optional direct-mapped I-cache under ICACHE_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [5:0]  stall,
  input  logic        branch_if,
  input  logic        jmp_e,
  input  logic [31:0] jmp_target,
  input  logic [7:0]  mem_if_data,
  input  logic        mem_if_valid,
  output logic        if_mem_req,
  output logic [31:0] if_mem_addr,
  output logic        if_stall_req,
  output logic        if_br,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_inst_valid
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ifPc_q, ifPc_d;
  logic        valid_q, valid_d;
  logic        br_q, br_d;
  logic        brPend_q, brPend_d;

  logic        abort;
  logic        cacheHit;
  logic [31:0] cacheRdData;
  logic        cacheWe;
  logic [31:0] cacheWrData;

  // A still-asserted branch_if is already being serviced while the restart is pending or acked.
  assign abort = jmp_e | (branch_if & ~brPend_q & ~br_q);
  assign cacheWrData = {mem_if_data, inst_q[23:0]};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    inst_d   = inst_q;
    ifPc_d   = ifPc_q;
    valid_d  = 1'b0;
    br_d     = 1'b0;
    brPend_d = brPend_q;
    cacheWe  = 1'b0;
    if (abort) begin
      state_d  = IDLE;
      cnt_d    = 2'd0;
      brPend_d = 1'b1;
      if (jmp_e) begin
        pc_d = jmp_target;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!stall[0]) begin
            if (cacheHit) begin
              if (!stall[1]) begin
                valid_d = 1'b1;
                inst_d  = cacheRdData;
                ifPc_d  = pc_q;
                pc_d    = pc_q + 32'd4;
              end
            end else begin
              state_d  = FETCH;
              cnt_d    = 2'd0;
              addr_d   = pc_q;
              br_d     = brPend_q;
              brPend_d = 1'b0;
            end
          end
        end
        FETCH: begin
          if (mem_if_valid) begin
            case (cnt_q)
              2'd0:    inst_d[7:0]   = mem_if_data;
              2'd1:    inst_d[15:8]  = mem_if_data;
              2'd2:    inst_d[23:16] = mem_if_data;
              default: inst_d[31:24] = mem_if_data;
            endcase
            cnt_d  = cnt_q + 2'd1;
            addr_d = addr_q + 32'd1;
            if (cnt_q == 2'd3) begin
              ifPc_d  = pc_q;
              cacheWe = 1'b1;
              if (!stall[1]) begin
                valid_d = 1'b1;
                pc_d    = pc_q + 32'd4;
                state_d = IDLE;
              end else begin
                state_d = HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (!stall[1]) begin
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      cnt_q    <= 2'd0;
      addr_q   <= 32'd0;
      inst_q   <= 32'd0;
      ifPc_q   <= 32'd0;
      valid_q  <= 1'b0;
      br_q     <= 1'b0;
      brPend_q <= 1'b0;
    end else if (rdy) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      inst_q   <= inst_d;
      ifPc_q   <= ifPc_d;
      valid_q  <= valid_d;
      br_q     <= br_d;
      brPend_q <= brPend_d;
    end
  end

`ifdef ICACHE_EN
  localparam int IW = $clog2(ICACHE_LINES);

  logic [31:0]         cacheData [ICACHE_LINES];
  logic [31-IW-2:0]    cacheTag  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] cacheValid_q;
  logic [IW-1:0]       cacheIdx;
  logic                unusedBits;

  // Written words always belong to pc_q, so one index serves lookup and fill.
  assign cacheIdx    = pc_q[IW+1:2];
  assign cacheRdData = cacheData[cacheIdx];
  assign cacheHit    = cacheValid_q[cacheIdx] & (cacheTag[cacheIdx] == pc_q[31:IW+2]) & ~brPend_q;
  assign unusedBits  = ^stall[5:2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      cacheValid_q <= '0;
    end else if (rdy && cacheWe && !abort) begin
      cacheValid_q[cacheIdx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy && cacheWe && !abort) begin
      cacheData[cacheIdx] <= cacheWrData;
      cacheTag[cacheIdx]  <= pc_q[31:IW+2];
    end
  end
`else
  logic unusedBits;

  assign cacheHit    = 1'b0;
  assign cacheRdData = 32'd0;
  assign unusedBits  = ^{stall[5:2], cacheWe, cacheWrData, (ICACHE_LINES != 0)};
`endif

  assign if_mem_req    = (state_q == FETCH);
  assign if_stall_req  = (state_q == FETCH);
  assign if_mem_addr   = addr_q;
  assign if_br         = br_q;
  assign if_pc         = ifPc_q;
  assign if_inst       = inst_q;
  assign if_inst_valid = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch (default build): byte-serial fetch, HOLD, redirects,
// rdy freeze, PC wrap and PC-hold stall, checked with immediate assertions.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [5:0]  stall;
  logic        branch_if;
  logic        jmp_e;
  logic [31:0] jmp_target;
  logic [7:0]  mem_if_data;
  logic        mem_if_valid;
  logic        if_mem_req;
  logic [31:0] if_mem_addr;
  logic        if_stall_req;
  logic        if_br;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_inst_valid;

  int checks = 0;
  int errors = 0;

  if_fetch #(.RESET_PC(32'h0), .ICACHE_LINES(64)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .branch_if(branch_if),
    .jmp_e(jmp_e), .jmp_target(jmp_target), .mem_if_data(mem_if_data),
    .mem_if_valid(mem_if_valid), .if_mem_req(if_mem_req), .if_mem_addr(if_mem_addr),
    .if_stall_req(if_stall_req), .if_br(if_br), .if_pc(if_pc), .if_inst(if_inst),
    .if_inst_valid(if_inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one memory byte (or none) and advance a cycle.
  task automatic applyStimulus(input logic v, input logic [7:0] d);
    mem_if_valid = v;
    mem_if_data  = d;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; stall = 6'b0; branch_if = 1'b0; jmp_e = 1'b0;
    jmp_target = 32'h0; mem_if_data = 8'h0; mem_if_valid = 1'b0;
    tick();
    tick();
    checkOutput("rst_req",   {31'b0, if_mem_req},    32'd0);
    checkOutput("rst_valid", {31'b0, if_inst_valid}, 32'd0);
    checkOutput("rst_addr",  if_mem_addr,            32'd0);
    checkOutput("rst_pc",    if_pc,                  32'd0);
    checkOutput("rst_br",    {31'b0, if_br},         32'd0);

    // First fetch at 0: 13 05 10 00 -> 00100513
    rst = 1'b1;
    tick();
    checkOutput("f0_req",   {31'b0, if_mem_req},   32'd1);
    checkOutput("f0_sreq",  {31'b0, if_stall_req}, 32'd1);
    checkOutput("f0_addr0", if_mem_addr,           32'd0);
    applyStimulus(1'b1, 8'h13);
    checkOutput("f0_addr1", if_mem_addr, 32'd1);
    applyStimulus(1'b1, 8'h05);
    applyStimulus(1'b1, 8'h10);
    checkOutput("f0_novalid", {31'b0, if_inst_valid}, 32'd0);
    applyStimulus(1'b1, 8'h00);
    checkOutput("f0_valid", {31'b0, if_inst_valid}, 32'd1);
    checkOutput("f0_inst",  if_inst,                32'h00100513);
    checkOutput("f0_pc",    if_pc,                  32'd0);
    checkOutput("f0_addr4", if_mem_addr,            32'd4);
    checkOutput("f0_reqoff",{31'b0, if_mem_req},    32'd0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("f1_pulse", {31'b0, if_inst_valid}, 32'd0);
    checkOutput("f1_req",   {31'b0, if_mem_req},    32'd1);
    checkOutput("f1_addr",  if_mem_addr,            32'd4);

    // Fetch at 4 with IF hold on the 4th byte -> HOLD
    applyStimulus(1'b1, 8'h93);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h00);
    stall = 6'b000011;
    applyStimulus(1'b1, 8'h00);
    checkOutput("hold_valid", {31'b0, if_inst_valid}, 32'd0);
    checkOutput("hold_sreq",  {31'b0, if_stall_req},  32'd0);
    checkOutput("hold_req",   {31'b0, if_mem_req},    32'd0);
    checkOutput("hold_inst",  if_inst,                32'h00000093);
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    checkOutput("hold_valid3", {31'b0, if_inst_valid}, 32'd0);
    stall = 6'b0;
    tick();
    checkOutput("rel_valid", {31'b0, if_inst_valid}, 32'd1);
    checkOutput("rel_inst",  if_inst,                32'h00000093);
    checkOutput("rel_pc",    if_pc,                  32'd4);
    tick();
    checkOutput("rel_once", {31'b0, if_inst_valid}, 32'd0);
    checkOutput("rel_addr", if_mem_addr,            32'd8);

    // Jump after 2 bytes of the fetch at 8
    applyStimulus(1'b1, 8'hAA);
    applyStimulus(1'b1, 8'hBB);
    checkOutput("j_addr10", if_mem_addr, 32'd10);
    jmp_e = 1'b1; jmp_target = 32'h100;
    applyStimulus(1'b0, 8'h00);
    jmp_e = 1'b0;
    checkOutput("j_req0",  {31'b0, if_mem_req},    32'd0);
    checkOutput("j_valid", {31'b0, if_inst_valid}, 32'd0);
    checkOutput("j_br0",   {31'b0, if_br},         32'd0);
    tick();
    checkOutput("j_br",    {31'b0, if_br},         32'd1);
    checkOutput("j_addr",  if_mem_addr,            32'h100);
    checkOutput("j_req1",  {31'b0, if_mem_req},    32'd1);

    // Jump coinciding with the 4th byte: byte dropped, no valid
    applyStimulus(1'b1, 8'h11);
    checkOutput("j2_br_once", {31'b0, if_br}, 32'd0);
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b1, 8'h33);
    jmp_e = 1'b1; jmp_target = 32'h200;
    applyStimulus(1'b1, 8'h44);
    jmp_e = 1'b0;
    checkOutput("j2_valid", {31'b0, if_inst_valid}, 32'd0);
    checkOutput("j2_req",   {31'b0, if_mem_req},    32'd0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("j2_br",   {31'b0, if_br}, 32'd1);
    checkOutput("j2_addr", if_mem_addr,    32'h200);

    // branch_if mid-fetch, held until the ack has been seen
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'h66);
    branch_if = 1'b1;
    applyStimulus(1'b0, 8'h00);
    checkOutput("b_req0",  {31'b0, if_mem_req},    32'd0);
    checkOutput("b_valid", {31'b0, if_inst_valid}, 32'd0);
    tick();
    checkOutput("b_br",    {31'b0, if_br},      32'd1);
    checkOutput("b_addr",  if_mem_addr,         32'h200);
    tick();
    branch_if = 1'b0;
    checkOutput("b_br_once", {31'b0, if_br},      32'd0);
    checkOutput("b_req1",    {31'b0, if_mem_req}, 32'd1);

    // rdy freeze after 2 bytes, junk byte offered while frozen
    applyStimulus(1'b1, 8'h37);
    applyStimulus(1'b1, 8'h12);
    rdy = 1'b0;
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'hFF);
    checkOutput("rdy_addr",  if_mem_addr,            32'h202);
    checkOutput("rdy_req",   {31'b0, if_mem_req},    32'd1);
    checkOutput("rdy_valid", {31'b0, if_inst_valid}, 32'd0);
    rdy = 1'b1;
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h00);
    checkOutput("rdy_ivalid", {31'b0, if_inst_valid}, 32'd1);
    checkOutput("rdy_inst",   if_inst,                32'h00001237);
    checkOutput("rdy_pc",     if_pc,                  32'h200);
    checkOutput("rdy_addr2",  if_mem_addr,            32'h204);

    // PC and address wrap at the top of memory
    jmp_e = 1'b1; jmp_target = 32'hFFFF_FFFC;
    applyStimulus(1'b0, 8'h00);
    jmp_e = 1'b0;
    tick();
    checkOutput("w_br",   {31'b0, if_br}, 32'd1);
    checkOutput("w_addr", if_mem_addr,    32'hFFFF_FFFC);
    applyStimulus(1'b1, 8'h6F);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h00);
    checkOutput("w_addrff", if_mem_addr, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 8'h00);
    checkOutput("w_valid", {31'b0, if_inst_valid}, 32'd1);
    checkOutput("w_inst",  if_inst,                32'h0000006F);
    checkOutput("w_pc",    if_pc,                  32'hFFFF_FFFC);
    checkOutput("w_addr0", if_mem_addr,            32'd0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("w_refetch", if_mem_addr, 32'd0);

    // PC hold while idle: no request until released
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h02);
    applyStimulus(1'b1, 8'h03);
    stall = 6'b000001;
    applyStimulus(1'b1, 8'h04);
    checkOutput("s_valid", {31'b0, if_inst_valid}, 32'd1);
    checkOutput("s_inst",  if_inst,                32'h04030201);
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    checkOutput("s_req",  {31'b0, if_mem_req},   32'd0);
    checkOutput("s_sreq", {31'b0, if_stall_req}, 32'd0);
    stall = 6'b0;
    tick();
    checkOutput("s_go_req",  {31'b0, if_mem_req}, 32'd1);
    checkOutput("s_go_addr", if_mem_addr,         32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage; sits directly upstream of the pipeline stall/branch controller.
- Owns the PC and fetches 32-bit instructions byte-serially from the shared memory controller.
- Drives if_stall_req while a fetch is outstanding.
- Consumes the stall bus and the branch_if discard flag; returns the if_br acknowledge that clears branch_if.

Parameters:
- RESET_PC, 32'h0, PC value loaded on reset.
- ICACHE_LINES, 64, instruction-cache depth in words (power of 2; used only with ICACHE_EN).

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  reset, synchronous, active-low
- rdy  in  1  global ready; when 0 all state freezes
- stall  in  6  stall bus; bit0 = PC hold, bit1 = IF hold
- branch_if  in  1  in-flight fetch is stale and must be discarded
- jmp_e  in  1  redirect request from EX
- jmp_target  in  32  redirect PC
- mem_if_data  in  8  returned byte
- mem_if_valid  in  1  mem_if_data valid this cycle
- if_mem_req  out  1  fetch request to memory controller
- if_mem_addr  out  32  byte address of the current request
- if_stall_req  out  1  fetch in progress (to stall controller)
- if_br  out  1  one-cycle ack: stale fetch dropped, redirect fetch started
- if_pc  out  32  PC of if_inst
- if_inst  out  32  assembled instruction
- if_inst_valid  out  1  if_pc/if_inst valid for the IF/ID latch

Behaviour:
- Reset (rst==0 at posedge): pc=RESET_PC, state=IDLE, byte count=0, all outputs 0, if_mem_addr=0.
- rdy==0: no register changes; outputs hold.
- FSM states: IDLE, FETCH, HOLD.
  - IDLE: if stall[0]==0, go to FETCH with byte count 0 and if_mem_addr=pc.
  - FETCH: if_mem_req=1 and if_stall_req=1.
    - On mem_if_valid, store the byte at inst[8k+7:8k], k=count, then count++ and if_mem_addr++.
    - Little-endian: the byte at pc+0 is inst[7:0].
    - After the 4th byte (k==3), drop if_mem_req next cycle.
    - If stall[1]==0: present if_inst_valid=1 for one cycle, pc<=pc+4, return to IDLE.
    - Else: go to HOLD.
  - HOLD: outputs stay stable, if_inst_valid=0, if_stall_req=0. Leave when stall[1]==0: pulse if_inst_valid for that cycle, pc<=pc+4, return to IDLE.
- Latency: 4 memory bytes + 1 cycle. Minimum 5 cycles per instruction with back-to-back mem_if_valid.
- Redirect: jmp_e==1 or branch_if==1 in any state:
  - abort the fetch (count=0, if_mem_req=0 for one cycle);
  - no if_inst_valid for the partially assembled word;
  - pc<=jmp_target (when jmp_e); enter IDLE.
  - Then if_br=1 for exactly the cycle FETCH restarts at the new pc.
  - If jmp_e and a 4th byte arrive in the same cycle, the redirect wins and the byte is discarded.
- A late mem_if_valid after an abort is ignored for 1 cycle. The memory controller is required to cancel on req deassert.
- PC wrap: pc+4 wraps modulo 2^32. if_mem_addr increments wrap identically.
- stall[0]==1 in IDLE: no new request; if_stall_req=0.

Optional Feature:
- Macro: ICACHE_EN.
- Defined: direct-mapped I-cache of ICACHE_LINES words.
  - Index = pc[log2(ICACHE_LINES)+1:2]; tag = remaining upper PC bits; valid bits cleared on reset.
  - In IDLE, a hit presents if_inst_valid next cycle with no memory request.
  - A miss runs FETCH, and the completed word is written to the cache.
  - Aborted fetches never write the cache.
- Undefined: no cache storage; every instruction uses FETCH.

Test Plan:
- Reset, RESET_PC=0, memory bytes 13,05,10,00 at addr 0..3, one byte per cycle → if_inst=32'h00100513, if_pc=0, if_inst_valid at cycle 5, then if_mem_addr=4.
- stall=6'b000011 held 3 cycles after 4th byte → HOLD, no valid pulse. Release → one valid pulse with unchanged inst; pc becomes 4.
- jmp_e=1, jmp_target=32'h100 after 2 bytes received → no valid, if_br=1 on restart, if_mem_addr=32'h100.
- branch_if=1 mid-fetch without jmp_e → partial word discarded; refetch at same pc; if_br pulses once.
- rdy=0 for 4 cycles mid-fetch → count, addr and outputs frozen; resumes correctly.
- ICACHE_EN defined: loop fetching addr 0 twice → second fetch has no if_mem_req, valid 1 cycle after IDLE.
